// File: rtl/arb_pkg.sv
// Shared types for the two-cache AXI read arbiter: FSM states, bus owner
// encoding and the beat counter width.
package arb_pkg;

  localparam int unsigned BEAT_CNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/axi_rr_pick.sv
// Two-way round-robin pick between the instruction and data caches.
// pick follows the owner encoding: 0 selects I, 1 selects D.
module axi_rr_pick (
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic pick
);

  // D wins when it is the only requester, or on a tie when I was granted last.
  assign pick = req_d & (~req_i | ~last);

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates the instruction and data cache read channels onto one AXI read
// port; one burst at a time, ownership held from address through last beat.
module axi_read_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  output logic              i_arready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  input  logic              i_rready,

  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic [1:0]        d_arburst,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  input  logic              d_rready,

  output logic              m_axi_arvalid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rlast,
  output logic              m_axi_rready,

  output logic              instruction_cache_reading,
  output logic              data_cache_reading,
  output logic              burst_err
);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, last_q;
  logic [BEAT_CNT_W-1:0] cnt_q;
  logic                  burst_err_q;
  logic                  pick;

  logic                  own_arvalid;
  logic [ADDR_W-1:0]     own_araddr;
  logic [7:0]            own_arlen;
  logic [2:0]            own_arsize;
  logic [1:0]            own_arburst;
  logic                  own_rready;
  logic                  ar_hs;
  logic                  r_hs;

  axi_rr_pick u_pick (
    .req_i (i_arvalid),
    .req_d (d_arvalid),
    .last  (last_q),
    .pick  (pick)
  );

  always_comb begin
    if (owner_q == OWN_D) begin
      own_arvalid = d_arvalid;
      own_araddr  = d_araddr;
      own_arlen   = d_arlen;
      own_arsize  = d_arsize;
      own_arburst = d_arburst;
      own_rready  = d_rready;
    end else begin
      own_arvalid = i_arvalid;
      own_araddr  = i_araddr;
      own_arlen   = i_arlen;
      own_arsize  = i_arsize;
      own_arburst = i_arburst;
      own_rready  = i_rready;
    end
  end

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_arvalid | d_arvalid) state_d = ST_ADDR;
      ST_ADDR: begin
        if (!own_arvalid)       state_d = ST_IDLE;
        else if (m_axi_arready) state_d = ST_DATA;
      end
      ST_DATA: if (r_hs && m_axi_rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner, round-robin history, beat counter and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_I;
      last_q      <= OWN_D;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
    end else begin
      burst_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (i_arvalid | d_arvalid) owner_q <= owner_e'(pick);
        ST_ADDR: begin
          if (ar_hs) begin
            cnt_q  <= {1'b0, own_arlen} + BEAT_CNT_W'(1);
            last_q <= owner_q;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            // Counter parks at 0 on overrun so a late rlast still flags once.
            if (cnt_q != '0) cnt_q <= cnt_q - BEAT_CNT_W'(1);
            if (m_axi_rlast)                   burst_err_q <= (cnt_q != BEAT_CNT_W'(1));
            else if (cnt_q == BEAT_CNT_W'(1))  burst_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    m_axi_arvalid             = 1'b0;
    m_axi_araddr              = own_araddr;
    m_axi_arlen               = own_arlen;
    m_axi_arsize              = own_arsize;
    m_axi_arburst             = own_arburst;
    m_axi_rready              = 1'b0;
    i_arready                 = 1'b0;
    d_arready                 = 1'b0;
    i_rvalid                  = 1'b0;
    d_rvalid                  = 1'b0;
    i_rlast                   = 1'b0;
    d_rlast                   = 1'b0;
    i_rdata                   = m_axi_rdata;
    d_rdata                   = m_axi_rdata;
    instruction_cache_reading = 1'b0;
    data_cache_reading        = 1'b0;
    case (state_q)
      ST_ADDR: begin
        m_axi_arvalid = own_arvalid;
        if (owner_q == OWN_D) begin
          d_arready          = m_axi_arready;
          data_cache_reading = 1'b1;
        end else begin
          i_arready                 = m_axi_arready;
          instruction_cache_reading = 1'b1;
        end
      end
      ST_DATA: begin
        m_axi_rready = own_rready;
        if (owner_q == OWN_D) begin
          d_rvalid           = m_axi_rvalid;
          d_rlast            = m_axi_rlast;
          data_cache_reading = 1'b1;
        end else begin
          i_rvalid                  = m_axi_rvalid;
          i_rlast                   = m_axi_rlast;
          instruction_cache_reading = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter.
module tb_axi_read_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic              clk, reset;
  logic              i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [ADDR_W-1:0] i_araddr;
  logic [7:0]        i_arlen;
  logic [2:0]        i_arsize;
  logic [1:0]        i_arburst;
  logic [DATA_W-1:0] i_rdata;
  logic              d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [ADDR_W-1:0] d_araddr;
  logic [7:0]        d_arlen;
  logic [2:0]        d_arsize;
  logic [1:0]        d_arburst;
  logic [DATA_W-1:0] d_rdata;
  logic              m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic [DATA_W-1:0] m_axi_rdata;
  logic              instruction_cache_reading, data_cache_reading, burst_err;

  int total = 0;
  int bad   = 0;

  axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_rlast(i_rlast), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arburst(d_arburst), .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_rlast(d_rlast), .d_rready(d_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready),
    .instruction_cache_reading(instruction_cache_reading),
    .data_cache_reading(data_cache_reading), .burst_err(burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an address from one requester and complete the handshake; ends in DATA.
  task automatic issue(input bit is_d, input logic [7:0] len);
    if (is_d) begin d_arvalid = 1'b1; d_arlen = len; end
    else      begin i_arvalid = 1'b1; i_arlen = len; end
    step();
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    i_arvalid = 1'b0;
    d_arvalid = 1'b0;
  endtask

  task automatic beat(input logic last, input logic [DATA_W-1:0] data);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = last;
    m_axi_rdata  = data;
    step();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_arvalid = 1'b1;
    m_axi_rvalid = 1'b1;
    step();
    step();
    #1;
    total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%0b exp=0", m_axi_arvalid); end
    total++; if ({instruction_cache_reading, data_cache_reading} !== 2'b00) begin bad++; $display("FAIL reset_reading got=%b exp=00", {instruction_cache_reading, data_cache_reading}); end
    total++; if ({m_axi_rready, i_rvalid, d_rvalid, i_arready, d_arready, burst_err} !== 6'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=000000", {m_axi_rready, i_rvalid, d_rvalid, i_arready, d_arready, burst_err}); end
    i_arvalid = 1'b0;
    m_axi_rvalid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_burst();
    i_arvalid = 1'b1; i_araddr = 64'h1000; i_arlen = 8'd7; i_arsize = 3'd3; i_arburst = 2'd1;
    #1;
    total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL single_idle_arvalid got=%0b exp=0", m_axi_arvalid); end
    step();
    #1;
    total++; if (m_axi_arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid got=%0b exp=1", m_axi_arvalid); end
    total++; if (m_axi_araddr !== 64'h1000) begin bad++; $display("FAIL single_araddr got=%0h exp=1000", m_axi_araddr); end
    total++; if (m_axi_arlen !== 8'd7) begin bad++; $display("FAIL single_arlen got=%0d exp=7", m_axi_arlen); end
    total++; if ({instruction_cache_reading, data_cache_reading} !== 2'b10) begin bad++; $display("FAIL single_owner got=%b exp=10", {instruction_cache_reading, data_cache_reading}); end
    m_axi_arready = 1'b1;
    #1;
    total++; if ({i_arready, d_arready} !== 2'b10) begin bad++; $display("FAIL single_arready got=%b exp=10", {i_arready, d_arready}); end
    step();
    i_arvalid = 1'b0; m_axi_arready = 1'b0; i_rready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'hA000 + 64'(k);
      m_axi_rlast  = (k == 7);
      #1;
      total++; if ({i_rvalid, d_rvalid, m_axi_rready} !== 3'b101) begin bad++; $display("FAIL single_beat%0d_valid got=%b exp=101", k, {i_rvalid, d_rvalid, m_axi_rready}); end
      total++; if (i_rdata !== 64'hA000 + 64'(k)) begin bad++; $display("FAIL single_beat%0d_data got=%0h exp=%0h", k, i_rdata, 64'hA000 + 64'(k)); end
      total++; if ({i_rlast, instruction_cache_reading, burst_err} !== {(k == 7), 1'b1, 1'b0}) begin bad++; $display("FAIL single_beat%0d_flags got=%b exp=%b", k, {i_rlast, instruction_cache_reading, burst_err}, {(k == 7), 1'b1, 1'b0}); end
      step();
    end
    m_axi_rlast = 1'b0;
    #1;
    total++; if ({instruction_cache_reading, burst_err} !== 2'b00) begin bad++; $display("FAIL single_end got=%b exp=00", {instruction_cache_reading, burst_err}); end
    total++; if ({m_axi_rready, i_rvalid} !== 2'b00) begin bad++; $display("FAIL single_stray_beat got=%b exp=00", {m_axi_rready, i_rvalid}); end
    m_axi_rvalid = 1'b0;
    step();
  endtask

  task automatic test_round_robin_and_abort();
    reset = 1'b1; step(); reset = 1'b0;
    i_araddr = 64'h100; d_araddr = 64'h200; i_arlen = 8'd0; d_arlen = 8'd0;
    i_arvalid = 1'b1; d_arvalid = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    step();
    #1;
    total++; if ({instruction_cache_reading, data_cache_reading} !== 2'b10) begin bad++; $display("FAIL rr_first got=%b exp=10", {instruction_cache_reading, data_cache_reading}); end
    total++; if (m_axi_araddr !== 64'h100) begin bad++; $display("FAIL rr_first_addr got=%0h exp=100", m_axi_araddr); end
    m_axi_arready = 1'b1; step(); m_axi_arready = 1'b0;
    beat(1'b1, 64'h1);
    #1;
    total++; if ({instruction_cache_reading, data_cache_reading} !== 2'b00) begin bad++; $display("FAIL rr_gap got=%b exp=00", {instruction_cache_reading, data_cache_reading}); end
    step();
    #1;
    total++; if ({instruction_cache_reading, data_cache_reading} !== 2'b01) begin bad++; $display("FAIL rr_second got=%b exp=01", {instruction_cache_reading, data_cache_reading}); end
    total++; if (m_axi_araddr !== 64'h200) begin bad++; $display("FAIL rr_second_addr got=%0h exp=200", m_axi_araddr); end
    m_axi_arready = 1'b1; step(); m_axi_arready = 1'b0;
    beat(1'b1, 64'h2);
    step();
    #1;
    total++; if ({instruction_cache_reading, data_cache_reading} !== 2'b10) begin bad++; $display("FAIL rr_third got=%b exp=10", {instruction_cache_reading, data_cache_reading}); end
    i_arvalid = 1'b0; d_arvalid = 1'b0; m_axi_arready = 1'b1;
    #1;
    total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL abort_arvalid got=%0b exp=0", m_axi_arvalid); end
    step();
    m_axi_arready = 1'b0;
    #1;
    total++; if ({instruction_cache_reading, data_cache_reading} !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b exp=00", {instruction_cache_reading, data_cache_reading}); end
    step();
  endtask

  task automatic test_short_burst();
    d_araddr = 64'h3000; d_rready = 1'b1;
    issue(1'b1, 8'd3);
    beat(1'b0, 64'h10);
    #1;
    total++; if ({burst_err, data_cache_reading} !== 2'b01) begin bad++; $display("FAIL short_beat1 got=%b exp=01", {burst_err, data_cache_reading}); end
    beat(1'b1, 64'h11);
    #1;
    total++; if ({burst_err, data_cache_reading} !== 2'b10) begin bad++; $display("FAIL short_err got=%b exp=10", {burst_err, data_cache_reading}); end
    step();
    #1;
    total++; if (burst_err !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%0b exp=0", burst_err); end
  endtask

  task automatic test_overrun();
    d_rready = 1'b1;
    issue(1'b1, 8'd1);
    beat(1'b0, 64'h20);
    beat(1'b0, 64'h21);
    #1;
    total++; if ({burst_err, data_cache_reading} !== 2'b11) begin bad++; $display("FAIL overrun_err got=%b exp=11", {burst_err, data_cache_reading}); end
    step();
    #1;
    total++; if ({burst_err, data_cache_reading} !== 2'b01) begin bad++; $display("FAIL overrun_hold got=%b exp=01", {burst_err, data_cache_reading}); end
    beat(1'b1, 64'h22);
    #1;
    total++; if ({burst_err, data_cache_reading} !== 2'b10) begin bad++; $display("FAIL overrun_last got=%b exp=10", {burst_err, data_cache_reading}); end
    step();
  endtask

  task automatic test_stall();
    d_rready = 1'b1;
    issue(1'b1, 8'd3);
    beat(1'b0, 64'h30);
    d_rready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 64'h31; m_axi_rlast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if ({m_axi_rready, d_rvalid} !== 2'b01) begin bad++; $display("FAIL stall%0d_ready got=%b exp=01", k, {m_axi_rready, d_rvalid}); end
      total++; if (dut.cnt_q !== 9'd3) begin bad++; $display("FAIL stall%0d_cnt got=%0d exp=3", k, dut.cnt_q); end
      step();
    end
    d_rready = 1'b1;
    #1;
    total++; if (m_axi_rready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b exp=1", m_axi_rready); end
    step();
    beat(1'b0, 64'h32);
    beat(1'b1, 64'h33);
    #1;
    total++; if ({burst_err, data_cache_reading} !== 2'b00) begin bad++; $display("FAIL stall_end got=%b exp=00", {burst_err, data_cache_reading}); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    i_rready = 1'b1;
    issue(1'b0, 8'd7);
    for (int k = 0; k < 3; k++) beat(1'b0, 64'h40 + 64'(k));
    m_axi_rvalid = 1'b1; m_axi_rdata = 64'h43;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++; if ({instruction_cache_reading, data_cache_reading, m_axi_arvalid} !== 3'b000) begin bad++; $display("FAIL midreset_state got=%b exp=000", {instruction_cache_reading, data_cache_reading, m_axi_arvalid}); end
    total++; if ({m_axi_rready, i_rvalid, d_rvalid, i_arready, d_arready, burst_err} !== 6'b0) begin bad++; $display("FAIL midreset_outputs got=%b exp=000000", {m_axi_rready, i_rvalid, d_rvalid, i_arready, d_arready, burst_err}); end
    m_axi_rvalid = 1'b0;
    i_arvalid = 1'b1; i_araddr = 64'h4000;
    step();
    #1;
    total++; if ({m_axi_arvalid, instruction_cache_reading} !== 2'b11) begin bad++; $display("FAIL midreset_regrant got=%b exp=11", {m_axi_arvalid, instruction_cache_reading}); end
    total++; if (m_axi_araddr !== 64'h4000) begin bad++; $display("FAIL midreset_addr got=%0h exp=4000", m_axi_araddr); end
    i_arvalid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    i_arvalid = 1'b0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_rready = 1'b0;
    d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arburst = '0; d_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin_and_abort();
    test_short_burst();
    test_overrun();
    test_stall();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, read address width.
REQ-002 SHALL have parameter DATA_W, default 64, read data width.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_arvalid/i_araddr/i_arlen/i_arsize/i_arburst  in  1/ADDR_W/8/3/2  instruction-cache read-address request.
REQ-006 SHALL have port i_arready  out  1  instruction-cache address accepted.
REQ-007 SHALL have ports i_rvalid/i_rdata/i_rlast  out  1/DATA_W/1  read data routed to the instruction cache.
REQ-008 SHALL have port i_rready  in  1  instruction cache accepts a beat.
REQ-009 SHALL have ports d_arvalid/d_araddr/d_arlen/d_arsize/d_arburst, d_arready, d_rvalid/d_rdata/d_rlast, d_rready, with widths and directions identical to the i_ ports, for the data cache.
REQ-010 SHALL have ports m_axi_arvalid/araddr/arlen/arsize/arburst  out  1/ADDR_W/8/3/2  shared AXI read-address channel.
REQ-011 SHALL have port m_axi_arready  in  1  slave address ready.
REQ-012 SHALL have ports m_axi_rvalid/rdata/rlast  in  1/DATA_W/1  shared AXI read-data channel.
REQ-013 SHALL have port m_axi_rready  out  1  master beat ready.
REQ-014 SHALL have ports instruction_cache_reading/data_cache_reading  out  1/1  bus currently owned by that cache.
REQ-015 SHALL have port burst_err  out  1  one-cycle pulse when beat count and rlast disagree.

Function
REQ-016 SHALL implement the states IDLE, ADDR and DATA, plus a registered owner bit (I or D).
REQ-017 In IDLE, if exactly one of i_arvalid/d_arvalid is high, the arbiter SHALL register that requester as owner and move to ADDR on the next edge.
REQ-018 In IDLE, if both are high, the arbiter SHALL grant the requester not granted last (round-robin); the first grant after reset SHALL go to I.
REQ-019 In ADDR, m_axi_ar* SHALL be driven combinationally from the owner's ar* signals, and owner arready SHALL equal m_axi_arready.
REQ-020 On m_axi_arvalid && m_axi_arready, the arbiter SHALL move to DATA, load the beat counter with arlen+1 (9-bit), and record the last grant.
REQ-021 In DATA, owner r* SHALL equal m_axi_r*, and m_axi_rready SHALL equal owner rready; each rvalid&&rready SHALL decrement the counter.
REQ-022 On a handshaked beat with m_axi_rlast, the arbiter SHALL return to IDLE; burst_err SHALL pulse if the counter was not 1 at that beat.
REQ-023 burst_err SHALL also pulse if the counter reaches 0 without rlast; the FSM SHALL then stay in DATA until rlast.
REQ-024 The non-owner, and both caches whenever the FSM is not in ADDR/DATA, SHALL see arready=0 and rvalid=0.
REQ-025 m_axi_arvalid and m_axi_rready SHALL be 0 in IDLE, so stray beats are neither accepted nor forwarded.
REQ-026 *_cache_reading SHALL be high for the owner throughout ADDR and DATA, and 0 in IDLE.
REQ-027 Minimum grant latency SHALL be 1 cycle (request seen in IDLE at cycle N, m_axi_arvalid at N+1), with at least one IDLE cycle between bursts.
REQ-028 A requester dropping arvalid in ADDR SHALL return the FSM to IDLE with no AXI handshake.

Reset
REQ-029 Reset SHALL force state IDLE, owner I, last-grant D, counter 0, burst_err 0, and all valid/ready/reading outputs 0; any in-flight burst is abandoned.

Structure
REQ-030 A shared package arb_pkg SHALL hold the state enum, the owner enum, and BEAT_CNT_W=9.
REQ-031 The 2-way round-robin pick SHALL be a sub-module axi_rr_pick (inputs req_i, req_d, last; output pick).

Verification
REQ-032 Only i_arvalid with araddr=0x1000, arlen=7: m_axi_araddr=0x1000 one cycle later, 8 beats go to i_r*, instruction_cache_reading high until the rlast beat, burst_err=0.
REQ-033 i_arvalid and d_arvalid both high from reset: I is served first, then D, and a subsequent tie goes to I again.
REQ-034 D burst with arlen=3 and rlast on beat 2: burst_err pulses once, and the FSM returns to IDLE.
REQ-035 d_rready held low for 3 cycles mid-burst: m_axi_rready=0 during those cycles, no beat is lost, and the counter is unchanged.
REQ-036 Reset asserted during DATA beat 4 of 8: the next cycle is IDLE, all outputs are 0, and a new I request is granted normally.
